// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: occupancy state and stall counter width.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int STALL_CNT_WIDTH = 32;

endpackage

// File: rtl/register_en_async_rstn.sv
// Data register with load enable and asynchronous active-low reset to RESET_VAL.
module register_en_async_rstn #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= RESET_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/skid_buffer_async_rstn.sv
// Two-entry valid/ready register slice; all outputs come straight from flops.
// Optional stall counter port enabled by SKID_BUFFER_STALL_CNT_EN.
//   state | meaning
//   EMPTY | nothing held
//   BUSY  | output register valid, skid empty
//   FULL  | output and skid registers both valid, input blocked
module skid_buffer_async_rstn
  import skid_buffer_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [WIDTH-1:0]           m_data
`ifdef SKID_BUFFER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt
`endif
);

  skid_state_t      state;
  logic             out_load;
  logic             skid_load;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] skid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (s_valid) state <= BUSY;
        BUSY: begin
          if (s_valid && !m_ready)      state <= FULL;
          else if (!s_valid && m_ready) state <= EMPTY;
        end
        FULL:    if (m_ready) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  assign m_valid = (state != EMPTY);
  assign s_ready = (state != FULL);

  always_comb begin
    out_load  = 1'b0;
    skid_load = 1'b0;
    out_d     = s_data;
    case (state)
      EMPTY: out_load = s_valid;
      BUSY: begin
        out_load  = s_valid && m_ready;
        skid_load = s_valid && !m_ready;
      end
      FULL: begin
        out_load = m_ready;
        out_d    = skid_q;
      end
      default: ;
    endcase
  end

  register_en_async_rstn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_out_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (out_load),
    .d    (out_d),
    .q    (m_data)
  );

  register_en_async_rstn #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid_reg (
    .clk  (clk),
    .rstn (rstn),
    .en   (skid_load),
    .d    (s_data),
    .q    (skid_q)
  );

`ifdef SKID_BUFFER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (m_valid && !m_ready && (stall_cnt != {STALL_CNT_WIDTH{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_skid_buffer_async_rstn.sv
// Directed and scoreboarded checks for skid_buffer_async_rstn (WIDTH=8).
module tb_skid_buffer_async_rstn;

  localparam int W = 8;
  localparam int N_RAND = 10000;

  logic         clk;
  logic         rstn;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  skid_buffer_async_rstn #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released away from any clock edge.
  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    rstn    = 1'b0;
    #2;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    s_valid = 1'b1; s_data = 8'h5A;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_preload: m_valid=%b m_data=%h expected 1/5a", m_valid, m_data);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: m_valid=%b s_ready=%b m_data=%h expected 0/1/00",
               m_valid, s_ready, m_data);
    end
    #1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = W'(i);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_s_ready[%0d]: got %b expected 1", i, s_ready);
      end
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== W'(i)) begin
        errors++;
        $display("FAIL stream_out[%0d]: m_valid=%b m_data=%h expected 1/%h", i, m_valid, m_data, W'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: m_valid=%b expected 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'hA1;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: m_valid=%b m_data=%h s_ready=%b expected 1/a1/1", m_valid, m_data, s_ready);
    end
    s_data = 8'hA2;
    tick();
    s_valid = 1'b0;
    s_data  = 8'hFF;
    checks++;
    if (s_ready !== 1'b0 || m_data !== 8'hA1) begin
      errors++;
      $display("FAIL bp_full: s_ready=%b m_data=%h expected 0/a1", s_ready, m_data);
    end
    tick();
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'hA1) begin
      errors++;
      $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%h expected 0/1/a1", s_ready, m_valid, m_data);
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_path: s_ready=%b expected 0", s_ready);
    end
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA2 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: m_valid=%b m_data=%h s_ready=%b expected 1/a2/1", m_valid, m_data, s_ready);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: m_valid=%b expected 0", m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    logic [W-1:0] last_m_data;
    logic         last_m_valid;
    logic         last_m_fire;
    logic         sr_before;
    int sent, recv, cyc;
    do_reset();
    sent = 0; recv = 0; cyc = 0;
    last_m_valid = 1'b0; last_m_fire = 1'b0; last_m_data = '0;
    s_valid = 1'b0;
    while ((sent < N_RAND || q.size() != 0) && cyc < 90000) begin
      if (!(s_valid && !s_ready)) begin
        s_valid = (sent < N_RAND) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data  = W'($urandom);
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      sr_before = s_ready;
      m_ready = ~m_ready;
      #1;
      checks++;
      if (s_ready !== sr_before) begin
        errors++;
        $display("FAIL rand_comb_path cyc %0d: s_ready=%b expected %b", cyc, s_ready, sr_before);
      end
      m_ready = ~m_ready;
      #1;
      if (last_m_valid && !last_m_fire) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== last_m_data) begin
          errors++;
          $display("FAIL rand_hold cyc %0d: m_valid=%b m_data=%h expected 1/%h", cyc, m_valid, m_data, last_m_data);
        end
      end
      if (m_valid && m_ready) begin
        exp_d = (q.size() != 0) ? q.pop_front() : ~m_data;
        checks++;
        if (m_data !== exp_d) begin
          errors++;
          $display("FAIL rand_data word %0d: got %h expected %h", recv, m_data, exp_d);
        end
        recv++;
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
      end
      last_m_valid = m_valid;
      last_m_fire  = m_valid && m_ready;
      last_m_data  = m_data;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (recv != N_RAND || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_count: received %0d m_valid=%b expected %0d/0 (cycles %0d)", recv, m_valid, N_RAND, cyc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0 || m_data !== 8'h11) begin
      errors++;
      $display("FAIL midrst_full: s_ready=%b m_data=%h expected 0/11", s_ready, m_data);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00) begin
      errors++;
      $display("FAIL midrst_clear: m_valid=%b s_ready=%b m_data=%h expected 0/1/00", m_valid, s_ready, m_data);
    end
    #1;
    rstn = 1'b1;
    s_valid = 1'b1; s_data = 8'h33;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h33 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_next: m_valid=%b m_data=%h s_ready=%b expected 1/33/1", m_valid, m_data, s_ready);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_alone: m_valid=%b expected 0", m_valid);
    end
    m_ready = 1'b0;
  endtask

`ifdef SKID_BUFFER_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stall_reset: got %h expected 0", stall_cnt);
    end
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h77;
    tick();
    s_valid = 1'b0;
    repeat (7) tick();
    checks++;
    if (stall_cnt !== 32'd7) begin
      errors++;
      $display("FAIL stall_count: got %0d expected 7", stall_cnt);
    end
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    repeat (3) tick();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h expected ffffffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_random();
`ifdef SKID_BUFFER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
